window_coef_sequencer: RTL and testbench
========================================

WINDOW_COEF_SEQUENCER -- requirements
Module: window_coef_sequencer

Interface
REQ-001 Parameters SHALL be: MAX_LEN, 256, maximum window length; ADDR_W, 8, coefficient address width; TIMEOUT, 1024, handshake timeout in cycles.
REQ-002 Port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-003 Port rst, input, 1; reset SHALL be synchronous and active-high.
REQ-004 Port start, input, 1, one-cycle request to build a window.
REQ-005 Port abort, input, 1, cancels an in-progress build.
REQ-006 Port win_type, input, 4, window type: 1 rect, 2 Tukey, 3 triangle, 4 Hann, 5 Hamming, 6 Blackman.
REQ-007 Port n, input, 16, window length; port lgn, input, 8, log2 of the length.
REQ-008 Ports busy, done and error, output, 1 each: build active; one-cycle completion pulse; one-cycle failure pulse.
REQ-009 Ports gen_en (output, 1), gen_win_type (output, 4), gen_n (output, 16), gen_lgn (output, 8) and gen_i (output, 16) SHALL drive the window-function generator.
REQ-010 Ports gen_busy, input, 1 and gen_win, input, signed 16 SHALL be returned by the generator.
REQ-011 Ports coef_we (output, 1), coef_addr (output, ADDR_W) and coef_data (output, signed 16) SHALL drive the coefficient RAM write port.

Function
REQ-012 The FSM SHALL have the states IDLE, CHECK, REQ, WAIT, WRITE, DRAIN, FIN and ERR.
REQ-013 IDLE: start=1 SHALL latch win_type, n and lgn into gen_* registers, clear idx to 0 and move to CHECK; start is ignored in every other state.
REQ-014 CHECK: if n==0, or n>MAX_LEN, or win_type is outside 1..6, the FSM SHALL go to ERR; otherwise it SHALL go to REQ.
REQ-015 REQ: gen_en=1 and gen_i=idx; on gen_busy=1 the FSM SHALL go to WAIT.
REQ-016 WAIT: gen_en=0; on gen_busy=0 the FSM SHALL capture gen_win and go to WRITE.
REQ-017 WRITE: for exactly one cycle, coef_we=1, coef_addr=idx[ADDR_W-1:0] and coef_data=the captured win.
REQ-018 WRITE exit: if idx==n-1 the FSM SHALL go to FIN; otherwise idx SHALL increment and the FSM SHALL go to REQ.
REQ-019 FIN SHALL pulse done=1 for one cycle and return to IDLE.
REQ-020 ERR SHALL pulse error=1 for one cycle and return to IDLE.
REQ-021 Timeout: a 16-bit counter SHALL clear on entry to REQ and to WAIT; if it reaches TIMEOUT while still in that state, the FSM SHALL go to DRAIN and set the error flag.
REQ-022 abort=1 in REQ, WAIT or WRITE SHALL force gen_en=0 and move to DRAIN; an abort in a WRITE cycle still completes that cycle's write.
REQ-023 DRAIN: the FSM SHALL wait for gen_busy=0 and then go to IDLE, pulsing error only if a timeout caused the entry; done SHALL NOT be pulsed.
REQ-024 abort in IDLE, FIN or ERR SHALL have no effect; if abort and start coincide in IDLE, start wins.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Exactly n writes SHALL occur per successful build, at strictly increasing addresses 0..n-1.
REQ-027 The per-coefficient cost SHALL be the generator latency + 3 cycles of sequencer overhead.
REQ-028 gen_win_type, gen_n and gen_lgn SHALL stay stable from CHECK until IDLE is re-entered.

Reset
REQ-029 When rst=1, the FSM SHALL go to IDLE.
REQ-030 When rst=1, idx, the timeout counter and the gen_* registers SHALL be 0.
REQ-031 When rst=1, gen_en, coef_we, coef_addr, coef_data, busy, done and error SHALL be 0.
REQ-032 A reset asserted mid-build SHALL take effect on the next edge, with no further writes and no done/error pulse.

Structure
REQ-033 A shared package SHALL hold the state enumeration, the win_type code constants (WIN_RECT=1 .. WIN_BLACKMAN=6) and the MAX_LEN/TIMEOUT defaults.
REQ-034 The generator SHALL NOT be instantiated inside this module.
REQ-035 The timeout counter SHALL be the single sub-module, handshake_timer (clear, enable, limit, expired).

Verification
REQ-036 Hann, n=64, lgn=6, generator model with a 5-cycle busy -> 64 writes at addr 0..63, one done pulse, each coef_data equal to the model output, error never set.
REQ-037 n=0, or n=300, or win_type=7 -> error pulse 2 cycles after start, no gen_en, no coef_we.
REQ-038 abort during WAIT at idx=10 -> gen_en stays 0, FSM drains until gen_busy=0, then idle; writes only at addr 0..9; no done.
REQ-039 model never raises gen_busy, TIMEOUT=16 -> error pulse after 16 cycles in REQ, busy drops, no writes.
REQ-040 start re-pulsed mid-build, and rst pulsed at idx=20 -> the second start is ignored; after rst every output is 0 and a fresh build n=8 succeeds.
REQ-041 rectangle, n=1 -> exactly one write at addr 0, then done.

Source files
------------

// File: rtl/window_coef_sequencer_pkg.sv
// Shared types and constants for the window coefficient sequencer.
package window_coef_sequencer_pkg;

  localparam int unsigned MAX_LEN_DEF = 256;
  localparam int unsigned TIMEOUT_DEF = 1024;
  localparam int unsigned WIN_TYPE_W  = 4;
  localparam int unsigned N_W         = 16;
  localparam int unsigned LGN_W       = 8;
  localparam int unsigned COEF_W      = 16;
  localparam int unsigned TMR_W       = 16;

  localparam logic [WIN_TYPE_W-1:0] WIN_RECT     = 4'd1;
  localparam logic [WIN_TYPE_W-1:0] WIN_TUKEY    = 4'd2;
  localparam logic [WIN_TYPE_W-1:0] WIN_TRIANGLE = 4'd3;
  localparam logic [WIN_TYPE_W-1:0] WIN_HANN     = 4'd4;
  localparam logic [WIN_TYPE_W-1:0] WIN_HAMMING  = 4'd5;
  localparam logic [WIN_TYPE_W-1:0] WIN_BLACKMAN = 4'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_WAIT,
    ST_WRITE,
    ST_DRAIN,
    ST_FIN,
    ST_ERR
  } seq_state_t;

  // True when the code names a window the generator knows how to build.
  function automatic logic win_type_valid(input logic [WIN_TYPE_W-1:0] t);
    logic v;
    case (t)
      WIN_RECT, WIN_TUKEY, WIN_TRIANGLE,
      WIN_HANN, WIN_HAMMING, WIN_BLACKMAN: v = 1'b1;
      default:                             v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/window_coef_sequencer_timer.sv
// Handshake watchdog: counts enabled cycles since the last clear.
module handshake_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_cnt_next;

  // Expired once the current enabled cycle is the limit-th one since clear.
  assign w_cnt_next = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign expired    = enable && (w_cnt_next >= {1'b0, limit});

  // Cycle counter; holds once the limit is reached.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (enable && !expired) begin
      r_cnt <= w_cnt_next[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/window_coef_sequencer.sv
// Sequences an external window-function generator over indices 0..n-1 and
// writes each returned coefficient into the coefficient RAM.
module window_coef_sequencer
  import window_coef_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIN_TYPE_W-1:0]    win_type,
  input  logic [N_W-1:0]           n,
  input  logic [LGN_W-1:0]         lgn,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     gen_en,
  output logic [WIN_TYPE_W-1:0]    gen_win_type,
  output logic [N_W-1:0]           gen_n,
  output logic [LGN_W-1:0]         gen_lgn,
  output logic [N_W-1:0]           gen_i,
  input  logic                     gen_busy,
  input  logic signed [COEF_W-1:0] gen_win,
  output logic                     coef_we,
  output logic [ADDR_W-1:0]        coef_addr,
  output logic signed [COEF_W-1:0] coef_data
);

  seq_state_t               r_state;
  logic [N_W-1:0]           r_idx;
  logic                     r_timed_out;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_error;
  logic                     r_gen_en;
  logic [WIN_TYPE_W-1:0]    r_gen_win_type;
  logic [N_W-1:0]           r_gen_n;
  logic [LGN_W-1:0]         r_gen_lgn;
  logic [N_W-1:0]           r_gen_i;
  logic                     r_coef_we;
  logic [ADDR_W-1:0]        r_coef_addr;
  logic signed [COEF_W-1:0] r_coef_data;

  logic w_tmr_en;
  logic w_tmr_clear;
  logic w_tmr_expired;
  logic w_params_ok;
  logic w_last;

  // Watchdog runs only in the handshake states and restarts on each entry:
  // it is held clear elsewhere and cleared on the REQ->WAIT edge.
  assign w_tmr_en    = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign w_tmr_clear = !w_tmr_en || ((r_state == ST_REQ) && gen_busy);

  // Build request sanity, evaluated on the latched copies.
  assign w_params_ok = (r_gen_n != '0) && (32'(r_gen_n) <= MAX_LEN) &&
                       win_type_valid(r_gen_win_type);
  assign w_last      = (r_idx == (r_gen_n - N_W'(1)));

  handshake_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_tmr_clear),
    .enable  (w_tmr_en),
    .limit   (TMR_W'(TIMEOUT)),
    .expired (w_tmr_expired)
  );

  // Build sequencer with registered outputs; done/error/coef_we are pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_timed_out    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_gen_en       <= 1'b0;
      r_gen_win_type <= '0;
      r_gen_n        <= '0;
      r_gen_lgn      <= '0;
      r_gen_i        <= '0;
      r_coef_we      <= 1'b0;
      r_coef_addr    <= '0;
      r_coef_data    <= '0;
    end else begin
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_coef_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_gen_win_type <= win_type;
            r_gen_n        <= n;
            r_gen_lgn      <= lgn;
            r_idx          <= '0;
            r_timed_out    <= 1'b0;
            r_busy         <= 1'b1;
            r_state        <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!w_params_ok) begin
            r_error <= 1'b1;
            r_state <= ST_ERR;
          end else begin
            r_gen_en <= 1'b1;
            r_gen_i  <= r_idx;
            r_state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (abort) begin
            r_gen_en <= 1'b0;
            r_state  <= ST_DRAIN;
          end else if (gen_busy) begin
            r_gen_en <= 1'b0;
            r_state  <= ST_WAIT;
          end else if (w_tmr_expired) begin
            r_gen_en    <= 1'b0;
            r_timed_out <= 1'b1;
            r_state     <= ST_DRAIN;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            r_state <= ST_DRAIN;
          end else if (!gen_busy) begin
            r_coef_we   <= 1'b1;
            r_coef_addr <= r_idx[ADDR_W-1:0];
            r_coef_data <= gen_win;
            r_state     <= ST_WRITE;
          end else if (w_tmr_expired) begin
            r_timed_out <= 1'b1;
            r_state     <= ST_DRAIN;
          end
        end
        ST_WRITE: begin
          // The write strobe for this cycle is already on the port; an abort
          // only prevents the next request.
          if (abort) begin
            r_state <= ST_DRAIN;
          end else if (w_last) begin
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_idx    <= r_idx + N_W'(1);
            r_gen_i  <= r_idx + N_W'(1);
            r_gen_en <= 1'b1;
            r_state  <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (!gen_busy) begin
            r_error     <= r_timed_out;
            r_timed_out <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_ERR: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_gen_en <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign gen_en       = r_gen_en;
  assign gen_win_type = r_gen_win_type;
  assign gen_n        = r_gen_n;
  assign gen_lgn      = r_gen_lgn;
  assign gen_i        = r_gen_i;
  assign coef_we      = r_coef_we;
  assign coef_addr    = r_coef_addr;
  assign coef_data    = r_coef_data;

endmodule

// File: tb/tb_window_coef_sequencer.sv
// Self-checking bench for window_coef_sequencer with a behavioural generator.
module tb_window_coef_sequencer;
  import window_coef_sequencer_pkg::*;

  localparam int unsigned TB_ADDR_W  = 8;
  localparam int unsigned TB_TIMEOUT = 16;
  localparam int unsigned GEN_LAT    = 5;

  logic                  clk      = 1'b0;
  logic                  rst      = 1'b1;
  logic                  start    = 1'b0;
  logic                  abort    = 1'b0;
  logic [3:0]            win_type = '0;
  logic [15:0]           n        = '0;
  logic [7:0]            lgn      = '0;
  logic                  busy, done, error, gen_en, coef_we;
  logic [3:0]            gen_win_type;
  logic [15:0]           gen_n, gen_i;
  logic [7:0]            gen_lgn;
  logic [TB_ADDR_W-1:0]  coef_addr;
  logic signed [15:0]    coef_data;

  // Generator model state
  logic                  gen_busy_m = 1'b0;
  logic signed [15:0]    gen_win_m  = '0;
  logic                  gen_dead   = 1'b0;
  int                    gen_rem    = 0;
  logic [3:0]            gm_t       = '0;
  logic [15:0]           gm_n       = '0;
  logic [15:0]           gm_i       = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0, err_cnt = 0, err_cyc = -1, en_cnt = 0, wr_cnt = 0;
  logic [TB_ADDR_W-1:0] exp_addr_q[$];
  logic signed [15:0]   exp_data_q[$];
  logic [TB_ADDR_W-1:0] mon_ea;
  logic signed [15:0]   mon_ed;

  always #5 clk = ~clk;

  window_coef_sequencer #(
    .MAX_LEN (256),
    .ADDR_W  (TB_ADDR_W),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .win_type     (win_type),
    .n            (n),
    .lgn          (lgn),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .gen_en       (gen_en),
    .gen_win_type (gen_win_type),
    .gen_n        (gen_n),
    .gen_lgn      (gen_lgn),
    .gen_i        (gen_i),
    .gen_busy     (gen_busy_m),
    .gen_win      (gen_win_m),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data)
  );

  // Arbitrary but distinct coefficient value per (type, length, index).
  function automatic logic signed [15:0] win_val(input logic [3:0] t, input logic [15:0] nn,
                                                 input logic [15:0] i);
    logic [31:0] acc;
    acc = 32'(t) * 32'd4099 + 32'(i) * 32'd53 + 32'(nn) * 32'd7;
    return $signed(acc[15:0] ^ 16'h5A5A);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Generator: accepts gen_en when idle, stays busy GEN_LAT cycles, then presents gen_win.
  always @(posedge clk) begin
    if (gen_busy_m) begin
      if (gen_rem <= 1) begin
        gen_busy_m <= 1'b0;
        gen_win_m  <= win_val(gm_t, gm_n, gm_i);
      end else begin
        gen_rem <= gen_rem - 1;
      end
    end else if (gen_en && !gen_dead) begin
      gen_busy_m <= 1'b1;
      gen_rem    <= GEN_LAT;
      gm_t       <= gen_win_type;
      gm_n       <= gen_n;
      gm_i       <= gen_i;
    end
  end

  // Monitor and write scoreboard.
  always @(negedge clk) begin
    if (coef_we) begin
      wr_cnt++;
      total++;
      if (exp_addr_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected: got addr=%0d data=%0d, required no write", coef_addr, coef_data);
      end else begin
        mon_ea = exp_addr_q.pop_front();
        mon_ed = exp_data_q.pop_front();
        if (coef_addr !== mon_ea || coef_data !== mon_ed) begin
          bad++;
          $display("FAIL write_value: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   coef_addr, coef_data, mon_ea, mon_ed);
        end
      end
    end
    if (done) done_cnt++;
    if (error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (gen_en) en_cnt++;
  end

  task automatic clear_mon();
    @(posedge clk);
    #1;
    done_cnt = 0; err_cnt = 0; err_cyc = -1; en_cnt = 0; wr_cnt = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic push_build(input logic [3:0] t, input logic [15:0] nn, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      exp_addr_q.push_back(TB_ADDR_W'(i));
      exp_data_q.push_back(win_val(t, nn, 16'(i)));
    end
  endtask

  task automatic do_start(input logic [3:0] t, input logic [15:0] nn, input logic [7:0] l,
                          output int s);
    @(negedge clk);
    win_type = t; n = nn; lgn = l; start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, error, gen_en, coef_we} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b, required 00000", {busy, done, error, gen_en, coef_we});
    end
    total++;
    if ({coef_addr, coef_data, gen_i} !== '0) begin
      bad++; $display("FAIL reset_data: got addr=%0d data=%0d gen_i=%0d, required 0", coef_addr, coef_data, gen_i);
    end
    total++;
    if ({gen_win_type, gen_n, gen_lgn} !== '0) begin
      bad++; $display("FAIL reset_gen: got type=%0d n=%0d lgn=%0d, required 0", gen_win_type, gen_n, gen_lgn);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hann();
    int s; bit ok;
    clear_mon();
    push_build(WIN_HANN, 16'd64, 64);
    do_start(WIN_HANN, 16'd64, 8'd6, s);
    wait_idle(64 * 12 + 40, ok);
    repeat (2) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL hann_idle: got busy stuck, required return to idle"); end
    total++; if (wr_cnt != 64) begin bad++; $display("FAIL hann_writes: got %0d, required 64", wr_cnt); end
    total++; if (exp_addr_q.size() != 0) begin bad++; $display("FAIL hann_missing: got %0d pending, required 0", exp_addr_q.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL hann_done: got %0d, required 1", done_cnt); end
    total++; if (err_cnt != 0) begin bad++; $display("FAIL hann_error: got %0d, required 0", err_cnt); end
  endtask

  localparam logic [3:0]  BAD_T [3] = '{4'd4, 4'd4, 4'd7};
  localparam logic [15:0] BAD_N [3] = '{16'd0, 16'd300, 16'd8};

  task automatic test_bad_params();
    int s; bit ok;
    for (int c = 0; c < 3; c++) begin
      clear_mon();
      do_start(BAD_T[c], BAD_N[c], 8'd3, s);
      wait_idle(10, ok);
      repeat (2) @(negedge clk);
      total++; if (!ok) begin bad++; $display("FAIL bad%0d_idle: got busy stuck, required idle", c); end
      total++; if (err_cnt != 1) begin bad++; $display("FAIL bad%0d_errcnt: got %0d, required 1", c, err_cnt); end
      total++; if (err_cyc != s + 2) begin bad++; $display("FAIL bad%0d_errcyc: got %0d, required %0d", c, err_cyc, s + 2); end
      total++; if (en_cnt != 0) begin bad++; $display("FAIL bad%0d_gen_en: got %0d, required 0", c, en_cnt); end
      total++; if (wr_cnt != 0 || done_cnt != 0) begin
        bad++; $display("FAIL bad%0d_wr_done: got wr=%0d done=%0d, required 0 0", c, wr_cnt, done_cnt);
      end
    end
  endtask

  task automatic test_timeout();
    int s; bit ok;
    gen_dead = 1'b1;
    clear_mon();
    do_start(WIN_RECT, 16'd4, 8'd2, s);
    wait_idle(60, ok);
    repeat (2) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL to_idle: got busy stuck, required idle"); end
    total++; if (err_cnt != 1) begin bad++; $display("FAIL to_errcnt: got %0d, required 1", err_cnt); end
    total++; if (err_cyc != s + 19) begin bad++; $display("FAIL to_errcyc: got %0d, required %0d", err_cyc, s + 19); end
    total++; if (en_cnt != 16) begin bad++; $display("FAIL to_req_cycles: got %0d, required 16", en_cnt); end
    total++; if (wr_cnt != 0 || done_cnt != 0) begin
      bad++; $display("FAIL to_wr_done: got wr=%0d done=%0d, required 0 0", wr_cnt, done_cnt);
    end
    gen_dead = 1'b0;
  endtask

  task automatic test_abort();
    int s, ec; bit ok, found;
    clear_mon();
    push_build(WIN_HANN, 16'd32, 10);
    do_start(WIN_HANN, 16'd32, 8'd5, s);
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (gen_i == 16'd10 && !gen_en && gen_busy_m) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (!found) begin bad++; $display("FAIL abort_reach: got no WAIT at idx 10, required reached"); end
    abort = 1'b1;
    ec = en_cnt;
    @(negedge clk);
    abort = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_drain_busy: got %b, required 1", busy); end
    wait_idle(30, ok);
    total++; if (!ok || gen_busy_m !== 1'b0) begin
      bad++; $display("FAIL abort_drain: got idle=%0d gen_busy=%b, required 1 0", ok, gen_busy_m);
    end
    repeat (2) @(negedge clk);
    total++; if (en_cnt != ec) begin bad++; $display("FAIL abort_gen_en: got %0d, required %0d", en_cnt, ec); end
    total++; if (wr_cnt != 10 || exp_addr_q.size() != 0) begin
      bad++; $display("FAIL abort_writes: got %0d pending=%0d, required 10 0", wr_cnt, exp_addr_q.size());
    end
    total++; if (done_cnt != 0 || err_cnt != 0) begin
      bad++; $display("FAIL abort_flags: got done=%0d err=%0d, required 0 0", done_cnt, err_cnt);
    end
  endtask

  task automatic test_restart_reset();
    int s; bit ok, found;
    clear_mon();
    push_build(WIN_HAMMING, 16'd40, 20);
    do_start(WIN_HAMMING, 16'd40, 8'd7, s);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (gen_i == 16'd5) begin found = 1'b1; break; end
    end
    start = 1'b1; win_type = WIN_RECT; n = 16'd3; lgn = 8'd2;
    @(negedge clk);
    start = 1'b0;
    total++; if (!found || gen_n !== 16'd40 || gen_win_type !== WIN_HAMMING || gen_lgn !== 8'd7) begin
      bad++; $display("FAIL restart_ignored: got n=%0d type=%0d lgn=%0d, required 40 5 7", gen_n, gen_win_type, gen_lgn);
    end
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (gen_i == 16'd20) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL rst_reach: got no idx 20, required reached"); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, error, gen_en, coef_we} !== 5'b0) begin
      bad++; $display("FAIL midrst_ctrl: got %b, required 00000", {busy, done, error, gen_en, coef_we});
    end
    total++;
    if ({coef_addr, coef_data, gen_i, gen_win_type, gen_n, gen_lgn} !== '0) begin
      bad++; $display("FAIL midrst_data: got addr=%0d data=%0d gen_i=%0d n=%0d, required 0", coef_addr, coef_data, gen_i, gen_n);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (wr_cnt != 20 || exp_addr_q.size() != 0 || done_cnt != 0 || err_cnt != 0) begin
      bad++; $display("FAIL midrst_after: got wr=%0d pending=%0d done=%0d err=%0d, required 20 0 0 0",
                      wr_cnt, exp_addr_q.size(), done_cnt, err_cnt);
    end
    clear_mon();
    push_build(WIN_TRIANGLE, 16'd8, 8);
    do_start(WIN_TRIANGLE, 16'd8, 8'd3, s);
    wait_idle(8 * 12 + 20, ok);
    repeat (2) @(negedge clk);
    total++; if (!ok || wr_cnt != 8 || exp_addr_q.size() != 0) begin
      bad++; $display("FAIL fresh_writes: got idle=%0d wr=%0d pending=%0d, required 1 8 0", ok, wr_cnt, exp_addr_q.size());
    end
    total++; if (done_cnt != 1 || err_cnt != 0) begin
      bad++; $display("FAIL fresh_flags: got done=%0d err=%0d, required 1 0", done_cnt, err_cnt);
    end
  endtask

  task automatic test_rect_one();
    int s; bit ok;
    clear_mon();
    push_build(WIN_RECT, 16'd1, 1);
    do_start(WIN_RECT, 16'd1, 8'd0, s);
    wait_idle(30, ok);
    repeat (2) @(negedge clk);
    total++; if (!ok || wr_cnt != 1 || exp_addr_q.size() != 0) begin
      bad++; $display("FAIL rect1_writes: got idle=%0d wr=%0d pending=%0d, required 1 1 0", ok, wr_cnt, exp_addr_q.size());
    end
    total++; if (done_cnt != 1 || err_cnt != 0) begin
      bad++; $display("FAIL rect1_flags: got done=%0d err=%0d, required 1 0", done_cnt, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_hann();
    test_bad_params();
    test_timeout();
    test_abort();
    test_restart_reset();
    test_rect_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by 1ms, required finish");
    $fatal(1);
  end

endmodule
